// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, instruction
// classes, datapath select codes and opcode/funct constants.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILL
  } cls_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  localparam logic [1:0] A3_RD = 2'b00;
  localparam logic [1:0] A3_RT = 2'b01;
  localparam logic [1:0] A3_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps IR contents to an instruction class
// plus the static ALU/extender/write-back selects that class needs.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr,
  output cls_t        cls,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic        ext_op,
  output logic [1:0]  a3_sel,
  output logic [1:0]  wd_sel
);

  logic [5:0] w_op;
  logic [5:0] w_fn;

  assign w_op = instr[31:26];
  assign w_fn = instr[5:0];

  always_comb begin
    cls       = C_ILL;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    a3_sel    = A3_RD;
    wd_sel    = WD_ALU;
    case (w_op)
      OP_RTYPE: begin
        if (instr == 32'd0) begin
          cls = C_NOP;
        end else begin
          case (w_fn)
            FN_ADDU: cls = C_ADDU;
            FN_SUBU: begin cls = C_SUBU; alu_op = ALU_SUB; end
            FN_JR:   cls = C_JR;
            default: cls = C_ILL;
          endcase
        end
      end
      OP_ORI: begin
        cls = C_ORI; alu_op = ALU_OR; alu_src_b = 1'b1; a3_sel = A3_RT;
      end
      OP_LUI: begin
        cls = C_LUI; alu_op = ALU_LUI; alu_src_b = 1'b1; a3_sel = A3_RT;
      end
      OP_LW: begin
        cls = C_LW; alu_src_b = 1'b1; ext_op = 1'b1; a3_sel = A3_RT; wd_sel = WD_DM;
      end
      OP_SW: begin
        cls = C_SW; alu_src_b = 1'b1; ext_op = 1'b1;
      end
      OP_BEQ:  begin cls = C_BEQ; alu_op = ALU_SUB; end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory handshake
// timeout, illegal-opcode policy and a retired-instruction counter.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT      = 16,
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             equ,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic             alu_src_b,
  output logic             ext_op,
  output logic [1:0]       a3_sel,
  output logic [1:0]       wd_sel,
  output logic             reg_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retired;

  cls_t       w_cls;
  logic [2:0] w_alu_op;
  logic       w_alu_src_b;
  logic       w_ext_op;
  logic [1:0] w_a3_sel;
  logic [1:0] w_wd_sel;
  logic       w_timeout;

  mc_decode u_decode (
    .instr     (instr),
    .cls       (w_cls),
    .alu_op    (w_alu_op),
    .alu_src_b (w_alu_src_b),
    .ext_op    (w_ext_op),
    .a3_sel    (w_a3_sel),
    .wd_sel    (w_wd_sel)
  );

  // The current waiting cycle is the last one allowed; an ack in it still wins.
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_state <= S_DECODE;
            r_wait  <= '0;
          end else if (w_timeout) begin
            r_state <= S_ERROR;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          case (w_cls)
            C_NOP, C_J, C_JAL, C_JR: begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + 1'b1;
            end
            C_ILL:   r_state <= ILLEGAL_HALT ? S_HALT : S_FETCH;
            default: r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (w_cls)
            C_LW, C_SW: r_state <= S_MEM;
            C_BEQ: begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + 1'b1;
            end
            default: r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_wait <= '0;
            if (w_cls == C_SW) begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + 1'b1;
            end else begin
              r_state <= S_WB;
            end
          end else if (w_timeout) begin
            r_state <= S_ERROR;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + 1'b1;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Outputs decode from state+instr (plus the handshakes); reset silences them at once.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    a3_sel    = A3_RD;
    wd_sel    = WD_ALU;
    reg_we    = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
          pc_we    = imem_ack;
        end
        S_DECODE: begin
          case (w_cls)
            C_J:   begin pc_we = 1'b1; pc_src = PC_JUMP; end
            C_JAL: begin
              pc_we = 1'b1; pc_src = PC_JUMP;
              reg_we = 1'b1; a3_sel = A3_RA; wd_sel = WD_PC;
            end
            C_JR:  begin pc_we = 1'b1; pc_src = PC_REG; end
            default: ;
          endcase
        end
        S_EXEC, S_MEM: begin
          alu_op    = w_alu_op;
          alu_src_b = w_alu_src_b;
          ext_op    = w_ext_op;
          if (r_state == S_EXEC && w_cls == C_BEQ) begin
            pc_we  = equ;
            pc_src = PC_BRANCH;
          end
          if (r_state == S_MEM) begin
            dmem_req = 1'b1;
            dmem_we  = (w_cls == C_SW);
          end
        end
        S_WB: begin
          reg_we = 1'b1;
          a3_sel = w_a3_sel;
          wd_sel = w_wd_sel;
        end
        default: ;
      endcase
    end
  end

  assign state   = r_state;
  assign halted  = (r_state == S_HALT);
  assign err     = (r_state == S_ERROR);
  assign retired = r_retired;

endmodule
